// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: mode encodings and sizing helper shared by the LED sweep engine
package led_pwm_pkg;
   localparam logic [1:0] MODE_OFF     = 2'd0;
   localparam logic [1:0] MODE_SWEEP   = 2'd1;
   localparam logic [1:0] MODE_CHASE   = 2'd2;
   localparam logic [1:0] MODE_BREATHE = 2'd3;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/led_sweep_pwm_if.sv
// led_sweep_pwm_if: animation controls in, LED pins and PWM wrap strobe out
interface led_sweep_pwm_if #(parameter int NUM_LEDS = 4);
   logic                enable;
   logic [1:0]          mode;
   logic [1:0]          speed;
   logic [NUM_LEDS-1:0] led;
   logic                pwm_wrap;
   modport master (output enable, mode, speed, input led, pwm_wrap);
   modport slave (input enable, mode, speed, output led, pwm_wrap);
endinterface

// File: rtl/led_pwm_channel.sv
// led_pwm_channel: one LED's brightness register and registered PWM comparator
module led_pwm_channel #(
   parameter int PWM_BITS = 10
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [PWM_BITS-1:0] bright_next,
   input  logic [PWM_BITS-1:0] pwm_ctr,
   output logic                led_on
);
   logic [PWM_BITS-1:0] brightness;
   // capture brightness, then compare it against the shared PWM ramp
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         brightness <= '0;
         led_on     <= 1'b0;
      end else begin
         brightness <= bright_next;
         led_on     <= pwm_ctr < brightness;
      end
endmodule

// File: rtl/led_sweep_pwm.sv
// led_sweep_pwm: N-channel LED animation engine (off/sweep/chase/breathe) with PWM dimming
module led_sweep_pwm import led_pwm_pkg::*; #(
   parameter int NUM_LEDS   = 4,
   parameter int PWM_BITS   = 10,
   parameter int CTR_WIDTH  = 26,
   parameter bit ACTIVE_LOW = 1
) (
   input logic             clk,
   input logic             rst_n,
   led_sweep_pwm_if.slave  bus
);
   localparam int POS_BITS = clog2(NUM_LEDS);
   localparam logic [PWM_BITS-1:0] MAX = '1;
   logic [CTR_WIDTH-1:0] ctr, step;
   logic [CTR_WIDTH:0]   up_sum;
   logic                 dir;
   logic [1:0]           mode_q;
   logic [PWM_BITS-1:0]  pwm_ctr, frac, top;
   logic [POS_BITS-1:0]  pos, pos_inc, pos_dec;
   logic [NUM_LEDS-1:0]  led_reg;
   logic                 pwm_wrap;
   assign step    = CTR_WIDTH'(1) << bus.speed;
   assign up_sum  = {1'b0, ctr} + {1'b0, step};
   assign pos     = ctr[CTR_WIDTH-1 -: POS_BITS];
   assign frac    = ctr[CTR_WIDTH-POS_BITS-1 -: PWM_BITS];
   assign top     = ctr[CTR_WIDTH-1 -: PWM_BITS];
   assign pos_inc = pos + POS_BITS'(1);
   assign pos_dec = pos - POS_BITS'(1);
   // animation counter: restart on mode change, bounce or wrap while enabled
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ctr    <= '0;
         dir    <= 1'b0;
         mode_q <= MODE_OFF;
      end else begin
         mode_q <= bus.mode;
         if (bus.mode != mode_q || mode_q == MODE_OFF) begin
            ctr <= '0;
            dir <= 1'b0;
         end else if (bus.enable) begin
            if (mode_q == MODE_CHASE) begin
               ctr <= ctr + step;
               dir <= 1'b0;
            end else if (!dir) begin
               ctr <= up_sum[CTR_WIDTH] ? '1 : up_sum[CTR_WIDTH-1:0];
               dir <= up_sum[CTR_WIDTH];
            end else begin
               ctr <= ctr < step ? '0 : ctr - step;
               dir <= !(ctr < step);
            end
         end
      end
   // free-running PWM ramp shared by all channels, with a strobe after its top value
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         pwm_ctr  <= '0;
         pwm_wrap <= 1'b0;
      end else begin
         pwm_ctr  <= pwm_ctr + PWM_BITS'(1);
         pwm_wrap <= pwm_ctr == MAX;
      end
   for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
      localparam logic [POS_BITS-1:0] IDX = POS_BITS'(i);
      logic up_hit, dn_hit;
      logic [PWM_BITS-1:0] bright_next;
      assign up_hit = IDX == pos_inc && (mode_q == MODE_CHASE || pos != POS_BITS'(NUM_LEDS-1));
      assign dn_hit = IDX == pos_dec && (mode_q == MODE_CHASE || pos != '0);
      assign bright_next = mode_q == MODE_OFF     ? '0 :
                           mode_q == MODE_BREATHE ? top :
                           IDX == pos             ? MAX :
                           up_hit                 ? frac :
                           dn_hit                 ? MAX - frac : '0;
      led_pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .bright_next (bright_next),
         .pwm_ctr     (pwm_ctr),
         .led_on      (led_reg[i])
      );
   end
   assign bus.led      = ACTIVE_LOW ? ~led_reg : led_reg;
   assign bus.pwm_wrap = pwm_wrap;
endmodule
